// File: rtl/gf128_pkg.sv
// gf128_pkg: shared constants and types for the GF(2^128) squaring chain.
//   FIELD_M   : field degree (operand width).
//   RED_TAPS  : low-order terms of f(x) = x^128 + x^7 + x^2 + x + 1.
//   RED_SPAN  : all set bits of RED_TAPS lie below this index.
//   state_e   : sequencer state encoding.
package gf128_pkg;

    localparam int FIELD_M = 128;
    localparam logic [FIELD_M-1:0] RED_TAPS = 128'h87;
    localparam int RED_SPAN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gf128_reduce.sv
// gf128_reduce: combinational 256 -> 128 bit reduction modulo
// f(x) = x^128 + x^7 + x^2 + x + 1.
//   p_i : 256-bit polynomial (degree <= 254 for squares).
//   r_o : p_i mod f, 128 bits.
// Two folds suffice: the first leaves at most 7 bits above x^127
// (from h<<7), and folding those back lands entirely below bit 14.
module gf128_reduce
    import gf128_pkg::*;
(
    input  logic [2*FIELD_M-1:0] p_i,
    output logic [FIELD_M-1:0]   r_o
);

    localparam int T_W = FIELD_M + RED_SPAN - 1;  // 135 bits after fold 1
    localparam int G_W = RED_SPAN - 1;            // overflow bits of fold 1

    logic [FIELD_M-1:0] h;
    logic [T_W-1:0]     t;
    logic [G_W-1:0]     g;

    always_comb begin
        h = p_i[2*FIELD_M-1:FIELD_M];
        t = {{G_W{1'b0}}, p_i[FIELD_M-1:0]};
        // x^128 == x^7 + x^2 + x + 1, so each high term folds onto the taps.
        for (int j = 0; j < RED_SPAN; j++) begin
            if (RED_TAPS[j]) begin
                t = t ^ ({{G_W{1'b0}}, h} << j);
            end
        end

        g   = t[T_W-1:FIELD_M];
        r_o = t[FIELD_M-1:0];
        for (int j = 0; j < RED_SPAN; j++) begin
            if (RED_TAPS[j]) begin
                r_o = r_o ^ ({{(FIELD_M-G_W){1'b0}}, g} << j);
            end
        end
    end

endmodule

// File: rtl/gf128_sqr.sv
// gf128_sqr: combinational squarer in GF(2)[x]. Squaring a binary polynomial
// just spreads the coefficients: a_i moves to bit 2i, odd bits are zero.
//   a_i : 128-bit operand, bit i = coefficient of x^i.
//   p_o : 256-bit unreduced square.
module gf128_sqr
    import gf128_pkg::*;
(
    input  logic [FIELD_M-1:0]   a_i,
    output logic [2*FIELD_M-1:0] p_o
);

    always_comb begin
        p_o = '0;
        for (int i = 0; i < FIELD_M; i++) begin
            p_o[2*i] = a_i[i];
        end
    end

endmodule

// File: rtl/gf128_sqr_chain_ctrl.sv
// gf128_sqr_chain_ctrl: computes A^(2^k) mod f(x) in GF(2^128), one
// square-and-reduce per clock, behind a start/done handshake.
//
// Handshake: start is sampled only while IDLE (busy=0); k and a_in are
// captured on that same edge. done is a one-cycle pulse and result is valid
// while done is high; result then holds until the next completion or rst.
// start is ignored while busy.
//
// Ports:
//   clk    : clock, rising edge.
//   rst    : synchronous active-high reset.
//   start  : request pulse.
//   k      : number of successive squarings (0..2^KW-1).
//   a_in   : operand, bit i = coefficient of x^i.
//   busy   : state is not IDLE.
//   done   : result valid pulse.
//   result : registered A^(2^k) mod f.
module gf128_sqr_chain_ctrl
    import gf128_pkg::*;
#(
    parameter int M  = FIELD_M,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [M-1:0]  a_in,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  result
);

    state_e            state_q, state_d;
    logic [M-1:0]      acc_q, acc_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic [M-1:0]      result_q, result_d;

    logic [2*M-1:0]    sq_full;
    logic [M-1:0]      acc_next;

    gf128_sqr u_sqr (
        .a_i (acc_q),
        .p_o (sq_full)
    );

    gf128_reduce u_reduce (
        .p_i (sq_full),
        .r_o (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = a_in;
                    cnt_d = k;
                    if (k == '0) begin
                        // Nothing to square: publish the operand directly.
                        state_d  = DONE;
                        result_d = a_in;
                    end else begin
                        state_d = SQR;
                    end
                end
            end
            SQR: begin
                acc_d = acc_next;
                cnt_d = cnt_q - 1'b1;
                // cnt counts remaining squarings including this one, so it
                // never reaches zero in SQR and cannot wrap.
                if (cnt_q == KW'(1)) begin
                    state_d  = DONE;
                    result_d = acc_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_gf128_sqr_chain_ctrl.sv
module tb_gf128_sqr_chain_ctrl;

  localparam int M  = 128;
  localparam int KW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] k;
  logic [M-1:0]  a_in;
  logic          busy;
  logic          done;
  logic [M-1:0]  result;

  int checks = 0;
  int errors = 0;
  logic [M-1:0] exp_q[$];

  gf128_sqr_chain_ctrl #(.M(M), .KW(KW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .k      (k),
    .a_in   (a_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain shift-and-add field multiply; x*v reduces by x^128 -> 0x87.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] v;
    r = '0;
    v = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ v;
      if (v[M-1]) v = (v << 1) ^ 128'h87;
      else        v = v << 1;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] pow2k(input logic [M-1:0] a, input int kk);
    logic [M-1:0] x;
    x = a;
    for (int i = 0; i < kk; i++) x = gf_mul(x, x);
    return x;
  endfunction

  task automatic check(input string name, input logic [M-1:0] got, input logic [M-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [M-1:0] a, input int kk, input bit push, input logic [M-1:0] want);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    k     = KW'(kk);
    if (push) exp_q.push_back(want);
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
  endtask

  // Called right after E0: done must appear in the cycle after edge E0+kk,
  // with busy high in every cycle before it.
  task automatic wait_done(input int kk);
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= kk + 3 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("latency", M'(n), M'(kk + 1));
        check("busy_in_done", M'(busy), M'(1));
      end else begin
        check("busy_while_running", M'(busy), M'(1));
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles for k=%0d", kk + 3, kk);
    end
  endtask

  task automatic run_op(input logic [M-1:0] a, input int kk, input logic [M-1:0] want);
    start_op(a, kk, 1'b1, want);
    wait_done(kk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %h with no pending request", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [M-1:0] ra;
    int           rk;

    rst   = 1'b1;
    start = 1'b0;
    k     = '0;
    a_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", M'(busy), M'(0));
    check("reset_done", M'(done), M'(0));
    check("reset_result", result, '0);
    rst = 1'b0;

    // x squared three times -> x^8
    run_op(128'h2, 3, 128'h100);
    // x^(2^7) = x^128 -> reduced taps
    run_op(128'h2, 7, 128'h87);
    // (x^64)^2 = x^128, exercises the upper-half fold
    run_op(128'h1 << 64, 1, 128'h87);

    // k=0 with start held into the done cycle: second start must be ignored
    @(negedge clk);
    start = 1'b1;
    a_in  = {M{1'b1}};
    k     = '0;
    exp_q.push_back({M{1'b1}});
    @(posedge clk);  // E0
    #1;
    a_in = 128'h5;
    k    = KW'(3);
    @(negedge clk);
    check("k0_done", M'(done), M'(1));
    @(posedge clk);  // DONE -> IDLE, start still high but must be ignored
    #1;
    start = 1'b0;
    @(negedge clk);
    check("k0_ignore_start_busy", M'(busy), M'(0));
    check("k0_result_hold", result, {M{1'b1}});

    // Frobenius identity: a^(2^128) = a
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      run_op(ra, 128, ra);
    end

    // maximum count
    ra = {$urandom, $urandom, $urandom, $urandom};
    run_op(ra, 255, pow2k(ra, 255));

    // reset in the middle of a long run
    start_op(128'h2, 200, 1'b0, '0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);  // E0+50
    @(negedge clk);
    check("midrst_busy", M'(busy), M'(0));
    check("midrst_result", result, '0);
    check("midrst_done", M'(done), M'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", M'(done), M'(0));
    run_op(128'h2, 1, 128'h4);

    // random pairs against the software model
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rk = $urandom_range(0, 40);
      run_op(ra, rk, pow2k(ra, rk));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", M'(exp_q.size()), M'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf128_sqr_chain_ctrl.md
Name: gf128_sqr_chain_ctrl

Overview:
- Sequencer that drives the 128-bit bit-interleave squarer to compute a repeated field square, A^(2^k) mod f(x), in GF(2^128).
- Reduction polynomial is f(x) = x^128 + x^7 + x^2 + x + 1.
- Performs one squaring plus reduction per clock.
- Sits beside the field multiplier in the ECC point-arithmetic datapath. It serves the Itoh-Tsujii inversion and the point-operation state machine through a start/done handshake.

Parameters:
- M, 128, field degree; fixed to match the squarer width.
- KW, 8, width of the squaring-count input (k up to 255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- k  in  KW  number of successive squarings; sampled with start.
- a_in  in  M  field element operand, polynomial basis, bit i = coeff of x^i; sampled with start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  single-cycle pulse; result valid.
- result  out  M  A^(2^k) mod f; holds its value until the next accepted start or rst.

Behaviour:
- Reset values:
  - state=IDLE.
  - busy=0, done=0, result=0.
  - Internal accumulator and counter are 0.
- States: IDLE, SQR, DONE.
- IDLE, start=1 at edge E0:
  - acc<=a_in, cnt<=k.
  - Next state is DONE if k==0, else SQR.
- IDLE, start=0: stay in IDLE.
- SQR, each edge:
  - acc<=reduce(square(acc)), cnt<=cnt-1.
  - When cnt==1, go to DONE.
  - start is ignored.
- DONE:
  - done=1 and result=acc for exactly one cycle, then IDLE.
  - start is ignored in DONE.
  - A new start is accepted from the following IDLE cycle onward.
- Latency:
  - done is high in the cycle following edge E0+k; for k=0 that is the cycle right after E0.
  - Back-to-back operations give throughput of one operation per k+2 cycles.
- result is registered. It updates only on entry to DONE and is stable in IDLE.
- square(): combinational 256-bit interleave (coefficient a_i goes to bit 2i; odd bits are 0), done by instantiating the existing 128-bit squarer.
- reduce(), two-fold reduction:
  - Fold 1: with h=p[255:128], t = p[127:0] ^ h ^ (h<<1) ^ (h<<2) ^ (h<<7), computed at 135 bits.
  - Fold 2: with g=t[134:128], r = t[127:0] ^ g ^ (g<<1) ^ (g<<2) ^ (g<<7).
  - No third fold is needed.
- Fully combinational per iteration: no pipeline registers inside square/reduce.
- rst asserted mid-operation: next edge forces IDLE, clears result and drops busy. No done pulse is produced.
- start held high continuously: one operation per IDLE visit, with no double capture in SQR or DONE.
- k=255: exactly 255 squarings. cnt must not wrap.

Decomposition:
- Package gf128_pkg holds:
  - FIELD_M=128.
  - Reduction tap constant RED_TAPS = 128'h87.
  - State encoding (IDLE=2'd0, SQR=2'd1, DONE=2'd2).
- Sub-module gf128_reduce: 256 to 128 bit combinational two-fold reducer, verified standalone.
- The squarer is reused unchanged.
- The top level holds only the FSM, counter, accumulator and result register.

Test Plan:
- a_in=128'h2 (x), k=3 -> done at cycle E0+3, result=128'h100 (x^8); busy high for cycles E0+1..E0+3.
- a_in=128'h2, k=7 -> x^128 reduces to result=128'h87.
- a_in=1<<64, k=1 -> result=128'h87; exercises the fold-1 path.
- a_in=all ones, k=0 -> done in the cycle right after E0, result=a_in unchanged; a second start during that done cycle is ignored.
- Random a_in, k=128 -> result==a_in (Frobenius identity a^(2^128)=a); compare also against a software model for 1000 random (a,k) pairs.
- a_in=128'h2, k=200, rst asserted at E0+50 -> busy=0, result=0 the next cycle, no done pulse; a fresh start with k=1 afterwards gives result=128'h4.
